alu_issue_seq: RTL and testbench
================================

// Module: alu_issue_seq
// PURPOSE
//  Multi-cycle issue sequencer that drives the datapath ALU: the producer end of the ALU's a/b/shamt/funct/ALUOp interface.
//  Accepts one MIPS-format instruction plus register operands per handshake and decodes it to ALU controls.
//  Holds the ALU inputs stable for a programmable settle time, then captures out/zero and returns a tagged result.
//  Sits between the register-read stage and writeback/branch logic.
// PARAMETERS
//  DATA_W         16  ALU operand width; b immediates are sign-extended to this width.
//  SETTLE_CYCLES   1  Cycles ALU inputs are held before capture, for add/sub/logic/shift (min 1).
//  MULDIV_CYCLES   4  Cycles held before capture for funct mul (011000) and div (011010) (min 1).
// PORTS
//  clk          in   1       Single clock, rising edge.
//  reset        in   1       Synchronous, active-high reset.
//  in_valid     in   1       Instruction and operands valid.
//  in_ready     out  1       Sequencer can accept; high only in IDLE.
//  instr        in   32      MIPS instruction word.
//  rs_val       in   DATA_W  rs register value.
//  rt_val       in   DATA_W  rt register value.
//  alu_a        out  DATA_W  To ALU a.
//  alu_b        out  DATA_W  To ALU b.
//  alu_shamt    out  5       To ALU shamt.
//  alu_funct    out  6       To ALU funct.
//  alu_op       out  2       To ALU ALUOp.
//  alu_out      in   32      From ALU out.
//  alu_zero     in   1       From ALU zero.
//  out_valid    out  1       Result valid.
//  out_ready    in   1       Consumer accepts result.
//  out_result   out  32      Captured ALU result.
//  out_zero     out  1       Captured zero flag.
//  out_dest     out  5       Destination register (rd for R-type, rt for I-type, 0 otherwise).
//  out_wr_en    out  1       Result is written back.
//  out_branch   out  1       beq taken (alu_zero=1 on a beq).
//  out_err      out  1       Illegal opcode/funct, or divide by zero.
// BEHAVIOUR
//  Reset: state=IDLE. in_ready=1, out_valid=0. All alu_* outputs, out_* data and flags are 0. Reset mid-op drops the instruction.
//  FSM: IDLE -> HOLD -> DONE -> IDLE.
//   IDLE: in_valid&in_ready registers the decode into alu_* regs. Counter loads SETTLE_CYCLES, or MULDIV_CYCLES for mul/div. Goes to HOLD.
//   HOLD: alu_* stay constant. Counter decrements. At count==1, captures alu_out/alu_zero into out_*. Goes to DONE.
//   DONE: out_valid=1 and outputs stable until out_ready. On out_valid&out_ready, goes to IDLE.
//  No bypass: accept-to-out_valid latency is N+1 cycles (N = selected hold count). The next accept is possible in the cycle after the handshake.
//  Decode, by opcode instr[31:26]:
//   000000 R-type: op=10, funct=instr[5:0], shamt=instr[10:6], a=rs, b=rt, dest=instr[15:11], wr_en=1.
//   001000 addi, 100011 lw: op=00, b=sext(instr[15:0]), dest=instr[20:16], wr_en=1.
//   101011 sw: op=00, b=sext(imm), wr_en=0, dest=0.
//   000100 beq: op=01, b=rt, wr_en=0, out_branch=alu_zero at capture.
//  Errors skip HOLD: the block goes IDLE->DONE directly, with out_err=1, out_result=0, wr_en=0, alu_* unchanged. Error cases:
//   - Other opcode.
//   - R-type funct outside {100000, 100010, 011000, 011010, 000000, 000010, 100101, 100100, 100111, 100110}.
//   - div with rt_val==0.
//  out_err=0 on every legal result. Counter width is clog2(max(SETTLE,MULDIV))+1; there is no wrap.
//  in_valid while busy is ignored (in_ready=0); the upstream holds.
// STRUCTURE
//  Package alu_defs_pkg: opcode and funct localparams, ALUOp codes (00 add, 01 sub, 10 funct), state encoding.
//  Sub-module alu_issue_decode (combinational): instr, rs_val, rt_val -> alu controls, dest, wr_en, is_muldiv, is_beq, err.
//  Top: FSM, hold counter, capture and result registers.
// TESTING
//  1. R add: instr=0x00221820, rs=5, rt=7, SETTLE=1 -> alu_op=10, funct=100000. out_valid 2 cycles after accept, result=12, dest=3, wr_en=1.
//  2. addi negative imm: rs=3, imm=0xFFFE -> alu_b=0xFFFE, op=00, dest=rt, result from ALU, out_err=0.
//  3. beq equal: rs=rt=9 -> op=01, out_branch=1, wr_en=0. Same with rt=8 -> out_branch=0.
//  4. mul with MULDIV=4: alu_* held 4 cycles, captured at cycle 5. Sweep SETTLE/MULDIV=1.
//  5. Errors: opcode 111111, funct 101010, and div with rt=0 -> DONE next cycle, out_err=1, result=0, wr_en=0.
//  6. Backpressure: out_ready=0 for 10 cycles -> out_* stable, in_ready=0. Assert reset in HOLD -> IDLE next cycle, all outputs 0.

Source files
------------

// File: rtl/alu_defs_pkg.sv
// Shared definitions for the ALU issue sequencer: opcodes, functs, ALUOp codes, FSM states.
package alu_defs_pkg;

    // Major opcodes (instr[31:26])
    localparam logic [5:0] OPC_RTYPE = 6'b000000;
    localparam logic [5:0] OPC_ADDI  = 6'b001000;
    localparam logic [5:0] OPC_LW    = 6'b100011;
    localparam logic [5:0] OPC_SW    = 6'b101011;
    localparam logic [5:0] OPC_BEQ   = 6'b000100;

    // R-type function codes (instr[5:0])
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_MUL = 6'b011000;
    localparam logic [5:0] FN_DIV = 6'b011010;
    localparam logic [5:0] FN_SLL = 6'b000000;
    localparam logic [5:0] FN_SRL = 6'b000010;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_NOR = 6'b100111;
    localparam logic [5:0] FN_XOR = 6'b100110;

    // ALUOp codes seen by the ALU
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // Sequencer states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // True for function codes the ALU implements
    function automatic logic funct_legal(input logic [5:0] f);
        logic ok;
        case (f)
            FN_ADD, FN_SUB, FN_MUL, FN_DIV, FN_SLL,
            FN_SRL, FN_OR, FN_AND, FN_NOR, FN_XOR: ok = 1'b1;
            default:                               ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/alu_issue_decode.sv
// Combinational decode of one MIPS instruction into ALU controls and writeback info.
module alu_issue_decode
    import alu_defs_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic [31:0]       instr,
    input  logic [DATA_W-1:0] rs_val,
    input  logic [DATA_W-1:0] rt_val,
    output logic [DATA_W-1:0] a,
    output logic [DATA_W-1:0] b,
    output logic [4:0]        shamt,
    output logic [5:0]        funct,
    output logic [1:0]        op,
    output logic [4:0]        dest,
    output logic              wr_en,
    output logic              is_muldiv,
    output logic              is_beq,
    output logic              err
);

    logic [5:0]        opcode_s;
    logic [5:0]        fn_s;
    logic [DATA_W-1:0] imm_sext_s;
    logic              unused_rs_idx_s;

    assign opcode_s   = instr[31:26];
    assign fn_s       = instr[5:0];
    // Immediate sign-extended to the operand width (DATA_W >= 16)
    assign imm_sext_s = DATA_W'(signed'(instr[15:0]));
    // Register numbers are resolved upstream; the rs index is not needed here
    assign unused_rs_idx_s = ^instr[25:21];

    // Opcode/funct decode with error classification
    always_comb begin
        a         = rs_val;
        b         = rt_val;
        shamt     = 5'd0;
        funct     = 6'd0;
        op        = ALUOP_ADD;
        dest      = 5'd0;
        wr_en     = 1'b0;
        is_muldiv = 1'b0;
        is_beq    = 1'b0;
        err       = 1'b0;
        case (opcode_s)
            OPC_RTYPE: begin
                op        = ALUOP_FUNCT;
                funct     = fn_s;
                shamt     = instr[10:6];
                dest      = instr[15:11];
                is_muldiv = (fn_s == FN_MUL) || (fn_s == FN_DIV);
                if (!funct_legal(fn_s)) begin
                    err = 1'b1;
                end else if ((fn_s == FN_DIV) && (rt_val == '0)) begin
                    err = 1'b1;
                end else begin
                    err = 1'b0;
                end
                wr_en = ~err;
            end
            OPC_ADDI, OPC_LW: begin
                b     = imm_sext_s;
                dest  = instr[20:16];
                wr_en = 1'b1;
            end
            OPC_SW: begin
                b = imm_sext_s;
            end
            OPC_BEQ: begin
                op     = ALUOP_SUB;
                is_beq = 1'b1;
            end
            default: begin
                err = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/alu_issue_seq.sv
// ALU issue sequencer: accepts an instruction, holds ALU inputs for a settle time,
// captures the ALU result and presents it with a valid/ready handshake.
module alu_issue_seq
    import alu_defs_pkg::*;
#(
    parameter int DATA_W        = 16,
    parameter int SETTLE_CYCLES = 1,
    parameter int MULDIV_CYCLES = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       instr,
    input  logic [DATA_W-1:0] rs_val,
    input  logic [DATA_W-1:0] rt_val,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [4:0]        alu_shamt,
    output logic [5:0]        alu_funct,
    output logic [1:0]        alu_op,
    input  logic [31:0]       alu_out,
    input  logic              alu_zero,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_result,
    output logic              out_zero,
    output logic [4:0]        out_dest,
    output logic              out_wr_en,
    output logic              out_branch,
    output logic              out_err
);

    localparam int MAX_HOLD = (SETTLE_CYCLES > MULDIV_CYCLES) ? SETTLE_CYCLES : MULDIV_CYCLES;
    localparam int CNT_W    = $clog2(MAX_HOLD) + 1;

    state_t state_r, state_s;

    logic [DATA_W-1:0] dec_a_s, dec_b_s;
    logic [4:0]        dec_shamt_s, dec_dest_s;
    logic [5:0]        dec_funct_s;
    logic [1:0]        dec_op_s;
    logic              dec_wr_en_s, dec_muldiv_s, dec_beq_s, dec_err_s;
    logic              accept_s;

    logic [CNT_W-1:0]  cnt_r;
    logic [DATA_W-1:0] alu_a_r, alu_b_r;
    logic [4:0]        alu_shamt_r;
    logic [5:0]        alu_funct_r;
    logic [1:0]        alu_op_r;
    logic [4:0]        pend_dest_r;
    logic              pend_wr_en_r, pend_beq_r;
    logic [31:0]       out_result_r;
    logic              out_zero_r, out_wr_en_r, out_branch_r, out_err_r;
    logic [4:0]        out_dest_r;

    alu_issue_decode #(.DATA_W(DATA_W)) u_decode (
        .instr     (instr),
        .rs_val    (rs_val),
        .rt_val    (rt_val),
        .a         (dec_a_s),
        .b         (dec_b_s),
        .shamt     (dec_shamt_s),
        .funct     (dec_funct_s),
        .op        (dec_op_s),
        .dest      (dec_dest_s),
        .wr_en     (dec_wr_en_s),
        .is_muldiv (dec_muldiv_s),
        .is_beq    (dec_beq_s),
        .err       (dec_err_s)
    );

    assign accept_s = in_valid && (state_r == ST_IDLE);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; illegal instructions skip the hold phase
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (in_valid) begin
                    state_s = dec_err_s ? ST_DONE : ST_HOLD;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_HOLD: begin
                if (cnt_r == CNT_W'(1)) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_HOLD;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_DONE;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // ALU input registers, hold counter and result capture
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r        <= '0;
            alu_a_r      <= '0;
            alu_b_r      <= '0;
            alu_shamt_r  <= 5'd0;
            alu_funct_r  <= 6'd0;
            alu_op_r     <= 2'd0;
            pend_dest_r  <= 5'd0;
            pend_wr_en_r <= 1'b0;
            pend_beq_r   <= 1'b0;
            out_result_r <= 32'd0;
            out_zero_r   <= 1'b0;
            out_dest_r   <= 5'd0;
            out_wr_en_r  <= 1'b0;
            out_branch_r <= 1'b0;
            out_err_r    <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s && dec_err_s) begin
                        // ALU inputs keep their previous values on an error
                        out_result_r <= 32'd0;
                        out_zero_r   <= 1'b0;
                        out_dest_r   <= 5'd0;
                        out_wr_en_r  <= 1'b0;
                        out_branch_r <= 1'b0;
                        out_err_r    <= 1'b1;
                    end else if (accept_s) begin
                        alu_a_r      <= dec_a_s;
                        alu_b_r      <= dec_b_s;
                        alu_shamt_r  <= dec_shamt_s;
                        alu_funct_r  <= dec_funct_s;
                        alu_op_r     <= dec_op_s;
                        pend_dest_r  <= dec_dest_s;
                        pend_wr_en_r <= dec_wr_en_s;
                        pend_beq_r   <= dec_beq_s;
                        cnt_r        <= dec_muldiv_s ? CNT_W'(MULDIV_CYCLES) : CNT_W'(SETTLE_CYCLES);
                    end
                end
                ST_HOLD: begin
                    if (cnt_r == CNT_W'(1)) begin
                        out_result_r <= alu_out;
                        out_zero_r   <= alu_zero;
                        out_dest_r   <= pend_dest_r;
                        out_wr_en_r  <= pend_wr_en_r;
                        out_branch_r <= pend_beq_r & alu_zero;
                        out_err_r    <= 1'b0;
                    end else begin
                        cnt_r <= cnt_r - CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    cnt_r <= cnt_r;
                end
                default: begin
                    cnt_r <= '0;
                end
            endcase
        end
    end

    assign in_ready   = (state_r == ST_IDLE);
    assign out_valid  = (state_r == ST_DONE);
    assign alu_a      = alu_a_r;
    assign alu_b      = alu_b_r;
    assign alu_shamt  = alu_shamt_r;
    assign alu_funct  = alu_funct_r;
    assign alu_op     = alu_op_r;
    assign out_result = out_result_r;
    assign out_zero   = out_zero_r;
    assign out_dest   = out_dest_r;
    assign out_wr_en  = out_wr_en_r;
    assign out_branch = out_branch_r;
    assign out_err    = out_err_r;

endmodule

// File: tb/tb_alu_issue_seq.sv
// Directed self-checking bench for alu_issue_seq with a behavioural ALU on the a/b/funct side.
module tb_alu_issue_seq;

    logic        clk;
    logic        reset;
    logic        in_valid, in_valid2;
    logic [31:0] instr;
    logic [15:0] rs_val, rt_val;
    logic        out_ready;

    logic        in_ready, out_valid, alu_zero, out_zero, out_wr_en, out_branch, out_err;
    logic [15:0] alu_a, alu_b;
    logic [4:0]  alu_shamt, out_dest;
    logic [5:0]  alu_funct;
    logic [1:0]  alu_op;
    logic [31:0] alu_out, out_result;

    logic        in_ready2, out_valid2, alu_zero2, out_zero2, out_wr_en2, out_branch2, out_err2;
    logic [15:0] alu_a2, alu_b2;
    logic [4:0]  alu_shamt2, out_dest2;
    logic [5:0]  alu_funct2;
    logic [1:0]  alu_op2;
    logic [31:0] alu_out2, out_result2;

    int n_vec  = 0;
    int n_miss = 0;
    int lat;

    // Behavioural ALU: sign-extended operands, 32-bit result
    function automatic logic [31:0] alu_model(input logic [15:0] a, input logic [15:0] b,
                                              input logic [4:0] sh, input logic [5:0] f,
                                              input logic [1:0] op);
        logic signed [31:0] sa, sb;
        logic [31:0] r;
        sa = {{16{a[15]}}, a};
        sb = {{16{b[15]}}, b};
        r  = 32'd0;
        case (op)
            2'b00: r = sa + sb;
            2'b01: r = sa - sb;
            2'b10: begin
                case (f)
                    6'h20: r = sa + sb;
                    6'h22: r = sa - sb;
                    6'h18: r = sa * sb;
                    6'h1a: r = (sb != 32'sd0) ? sa / sb : 32'd0;
                    6'h00: r = sb << sh;
                    6'h02: r = sb >> sh;
                    6'h25: r = sa | sb;
                    6'h24: r = sa & sb;
                    6'h27: r = ~(sa | sb);
                    6'h26: r = sa ^ sb;
                    default: r = 32'd0;
                endcase
            end
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    assign alu_out   = alu_model(alu_a, alu_b, alu_shamt, alu_funct, alu_op);
    assign alu_zero  = (alu_out == 32'd0);
    assign alu_out2  = alu_model(alu_a2, alu_b2, alu_shamt2, alu_funct2, alu_op2);
    assign alu_zero2 = (alu_out2 == 32'd0);

    alu_issue_seq #(.DATA_W(16), .SETTLE_CYCLES(1), .MULDIV_CYCLES(4)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .rs_val(rs_val), .rt_val(rt_val),
        .alu_a(alu_a), .alu_b(alu_b), .alu_shamt(alu_shamt), .alu_funct(alu_funct), .alu_op(alu_op),
        .alu_out(alu_out), .alu_zero(alu_zero),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result), .out_zero(out_zero),
        .out_dest(out_dest), .out_wr_en(out_wr_en), .out_branch(out_branch), .out_err(out_err)
    );

    alu_issue_seq #(.DATA_W(16), .SETTLE_CYCLES(2), .MULDIV_CYCLES(1)) dut2 (
        .clk(clk), .reset(reset), .in_valid(in_valid2), .in_ready(in_ready2),
        .instr(instr), .rs_val(rs_val), .rt_val(rt_val),
        .alu_a(alu_a2), .alu_b(alu_b2), .alu_shamt(alu_shamt2), .alu_funct(alu_funct2), .alu_op(alu_op2),
        .alu_out(alu_out2), .alu_zero(alu_zero2),
        .out_valid(out_valid2), .out_ready(out_ready), .out_result(out_result2), .out_zero(out_zero2),
        .out_dest(out_dest2), .out_wr_en(out_wr_en2), .out_branch(out_branch2), .out_err(out_err2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Present one instruction to an idle sequencer; returns 1 ns after the accepting edge
    task automatic issue(input bit which, input logic [31:0] i, input logic [15:0] rs, input logic [15:0] rt);
        instr  = i;
        rs_val = rs;
        rt_val = rt;
        if (which) in_valid2 = 1'b1;
        else       in_valid  = 1'b1;
        @(posedge clk); #1;
        in_valid  = 1'b0;
        in_valid2 = 1'b0;
    endtask

    // Cycles from the accept cycle (cycle 0) until out_valid is seen, bounded
    task automatic wait_out(input bit which, output int l);
        l = 1;
        while (((which ? out_valid2 : out_valid) == 1'b0) && (l < 40)) begin
            @(posedge clk); #1;
            l++;
        end
    endtask

    // Complete the output handshake (out_ready is high)
    task automatic drain();
        @(posedge clk); #1;
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_valid2 = 1'b0; out_ready = 1'b1;
        instr = 32'd0; rs_val = 16'd0; rt_val = 16'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_alu_a", {16'd0, alu_a}, 32'd0);
        chk("rst_out_err", {31'd0, out_err}, 32'd0);
        reset = 1'b0;

        // R add 5+7
        issue(1'b0, 32'h0022_1820, 16'd5, 16'd7);
        chk("add_op", {30'd0, alu_op}, 32'd2);
        chk("add_funct", {26'd0, alu_funct}, 32'h20);
        chk("add_in_ready", {31'd0, in_ready}, 32'd0);
        wait_out(1'b0, lat);
        chk("add_lat", lat, 32'd2);
        chk("add_res", out_result, 32'd12);
        chk("add_dest", {27'd0, out_dest}, 32'd3);
        chk("add_wr", {31'd0, out_wr_en}, 32'd1);
        chk("add_err", {31'd0, out_err}, 32'd0);
        drain();
        chk("add_idle", {31'd0, in_ready}, 32'd1);

        // R sub 5-7
        issue(1'b0, 32'h0022_1822, 16'd5, 16'd7);
        wait_out(1'b0, lat);
        chk("sub_res", out_result, 32'hFFFF_FFFE);
        drain();

        // sll by 4 of rt=3
        issue(1'b0, 32'h0002_1900, 16'd0, 16'd3);
        chk("sll_shamt", {27'd0, alu_shamt}, 32'd4);
        wait_out(1'b0, lat);
        chk("sll_res", out_result, 32'd48);
        drain();

        // addi with negative immediate: 3 + (-2)
        issue(1'b0, 32'h2024_FFFE, 16'd3, 16'd0);
        chk("addi_b", {16'd0, alu_b}, 32'h0000_FFFE);
        chk("addi_op", {30'd0, alu_op}, 32'd0);
        wait_out(1'b0, lat);
        chk("addi_res", out_result, 32'd1);
        chk("addi_dest", {27'd0, out_dest}, 32'd4);
        chk("addi_err", {31'd0, out_err}, 32'd0);
        drain();

        // sw: address 0x100 + 0x10, no writeback
        issue(1'b0, 32'hAC22_0010, 16'h0100, 16'd55);
        wait_out(1'b0, lat);
        chk("sw_res", out_result, 32'h110);
        chk("sw_wr", {31'd0, out_wr_en}, 32'd0);
        chk("sw_dest", {27'd0, out_dest}, 32'd0);
        drain();

        // beq equal then unequal
        issue(1'b0, 32'h1022_0005, 16'd9, 16'd9);
        chk("beq_op", {30'd0, alu_op}, 32'd1);
        wait_out(1'b0, lat);
        chk("beq_eq_br", {31'd0, out_branch}, 32'd1);
        chk("beq_eq_wr", {31'd0, out_wr_en}, 32'd0);
        drain();
        issue(1'b0, 32'h1022_0005, 16'd9, 16'd8);
        wait_out(1'b0, lat);
        chk("beq_ne_br", {31'd0, out_branch}, 32'd0);
        drain();

        // mul 6*7 with a 4-cycle hold
        issue(1'b0, 32'h0022_1818, 16'd6, 16'd7);
        for (int k = 1; k <= 4; k++) begin
            chk("mul_hold_a", {16'd0, alu_a}, 32'd6);
            chk("mul_hold_b", {16'd0, alu_b}, 32'd7);
            chk("mul_hold_valid", {31'd0, out_valid}, 32'd0);
            @(posedge clk); #1;
        end
        chk("mul_valid_c5", {31'd0, out_valid}, 32'd1);
        chk("mul_res", out_result, 32'd42);
        drain();

        // legal div 42/6
        issue(1'b0, 32'h0022_181A, 16'd42, 16'd6);
        wait_out(1'b0, lat);
        chk("div_lat", lat, 32'd5);
        chk("div_res", out_result, 32'd7);
        drain();

        // Errors: bad opcode, bad funct, divide by zero
        issue(1'b0, 32'hFC00_0000, 16'd1, 16'd2);
        wait_out(1'b0, lat);
        chk("eop_lat", lat, 32'd1);
        chk("eop_err", {31'd0, out_err}, 32'd1);
        chk("eop_res", out_result, 32'd0);
        chk("eop_alu_a_kept", {16'd0, alu_a}, 32'd42);
        drain();
        issue(1'b0, 32'h0022_182A, 16'd1, 16'd2);
        wait_out(1'b0, lat);
        chk("efn_lat", lat, 32'd1);
        chk("efn_err", {31'd0, out_err}, 32'd1);
        chk("efn_wr", {31'd0, out_wr_en}, 32'd0);
        drain();
        issue(1'b0, 32'h0022_181A, 16'd9, 16'd0);
        wait_out(1'b0, lat);
        chk("ediv_lat", lat, 32'd1);
        chk("ediv_err", {31'd0, out_err}, 32'd1);
        chk("ediv_res", out_result, 32'd0);
        drain();

        // Backpressure: result must hold and new instructions be ignored
        out_ready = 1'b0;
        issue(1'b0, 32'h0022_1820, 16'd5, 16'd7);
        wait_out(1'b0, lat);
        instr = 32'h0022_1822; rs_val = 16'd100; rt_val = 16'd1; in_valid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            chk("bp_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
            chk("bp_res", out_result, 32'd12);
            chk("bp_alu_a", {16'd0, alu_a}, 32'd5);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_valid", {31'd0, out_valid}, 32'd0);
        chk("bp_release_ready", {31'd0, in_ready}, 32'd1);

        // Reset while holding a mul
        issue(1'b0, 32'h0022_1818, 16'd6, 16'd7);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        chk("hrst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("hrst_valid", {31'd0, out_valid}, 32'd0);
        chk("hrst_alu_a", {16'd0, alu_a}, 32'd0);
        chk("hrst_alu_funct", {26'd0, alu_funct}, 32'd0);
        chk("hrst_res", out_result, 32'd0);
        chk("hrst_dest", {27'd0, out_dest}, 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("hrst_stays_idle", {31'd0, out_valid}, 32'd0);

        // Second configuration: SETTLE=2, MULDIV=1
        issue(1'b1, 32'h0022_1820, 16'd5, 16'd7);
        wait_out(1'b1, lat);
        chk("s2_add_lat", lat, 32'd3);
        chk("s2_add_res", out_result2, 32'd12);
        drain();
        issue(1'b1, 32'h0022_1818, 16'd6, 16'd7);
        wait_out(1'b1, lat);
        chk("m1_mul_lat", lat, 32'd2);
        chk("m1_mul_res", out_result2, 32'd42);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
